// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_pkg
// Description : Shared definitions for the butterfly engine. Contains the FSM
//               state encoding, the output-width function and the rounding
//               mode selectors.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

    // Engine sequencing states (2-bit explicit encoding)
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROC  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Product rescale modes
    localparam int c_round_trunc   = 0;
    localparam int c_round_half_up = 1;

    // Output component width: W-bit m plus a rescaled (2W+1-P)-bit product,
    // with one guard bit so m +/- prod can never wrap.
    function automatic int fft_ow(input int w, input int p);
        return 2 * w - p + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shared_butterfly_engine_cmul.sv
`default_nettype none
// ============================================================================
// Module      : shared_butterfly_engine_cmul
// Description : Combinational full-precision complex multiplier.
//               o = a * b, or a * conj(b) when i_conj is set. Operands are
//               packed {real, imag}; each result component is 2W+1 bits,
//               enough for the (-2^(W-1))^2 * 2 corner case.
// Revision    : 1.0 - initial release
// ============================================================================
module shared_butterfly_engine_cmul #(
    parameter int P_WIDTH = 8
) (
    input  logic [2*P_WIDTH-1:0] i_a,
    input  logic [2*P_WIDTH-1:0] i_b,
    input  logic                 i_conj,
    output logic [2*P_WIDTH:0]   o_re,
    output logic [2*P_WIDTH:0]   o_im
);

    localparam int c_pw = 2 * P_WIDTH + 1;

    logic signed [c_pw-1:0] w_ar;
    logic signed [c_pw-1:0] w_ai;
    logic signed [c_pw-1:0] w_br;
    logic signed [c_pw-1:0] w_bi;
    logic signed [c_pw-1:0] w_rr;
    logic signed [c_pw-1:0] w_ii;
    logic signed [c_pw-1:0] w_ri;
    logic signed [c_pw-1:0] w_ir;

    // Sign-extend operands to the product width, form the four partial
    // products and combine them with the conjugate-dependent signs.
    always_comb begin
        w_ar = {{(P_WIDTH+1){i_a[2*P_WIDTH-1]}}, i_a[2*P_WIDTH-1:P_WIDTH]};
        w_ai = {{(P_WIDTH+1){i_a[P_WIDTH-1]}},   i_a[P_WIDTH-1:0]};
        w_br = {{(P_WIDTH+1){i_b[2*P_WIDTH-1]}}, i_b[2*P_WIDTH-1:P_WIDTH]};
        w_bi = {{(P_WIDTH+1){i_b[P_WIDTH-1]}},   i_b[P_WIDTH-1:0]};
        w_rr = w_ar * w_br;
        w_ii = w_ai * w_bi;
        w_ri = w_ar * w_bi;
        w_ir = w_ai * w_br;
        if (i_conj) begin
            o_re = w_rr + w_ii;
            o_im = w_ir - w_ri;
        end else begin
            o_re = w_rr - w_ii;
            o_im = w_ri + w_ir;
        end
    end

endmodule
`default_nettype wire

// File: rtl/shared_butterfly_engine.sv
`default_nettype none
// ============================================================================
// Module      : shared_butterfly_engine
// Description : Batch radix-2 butterfly engine. A batch of C channels is
//               captured on acceptance, then one shared complex multiplier
//               and one add/sub pair are stepped across the channels:
//               o_p = m + rescale(n*l), o_m = m - rescale(n*l).
//               Results are held until the downstream consumes them.
// Revision    : 1.0 - initial release
// ============================================================================
module shared_butterfly_engine
    import fft_pkg::*;
#(
    parameter int P_INPUT_WIDTH    = 8,
    parameter int P_POINT_POSITION = 3,
    parameter int P_CHANNELS       = 4,
    parameter int P_ROUND          = 0
) (
    input  logic                                    CLK,
    input  logic                                    RST_N,
    input  logic                                    i_valid,
    output logic                                    o_ready,
    input  logic                                    i_conj,
    input  logic [P_CHANNELS*2*P_INPUT_WIDTH-1:0]   i_m,
    input  logic [P_CHANNELS*2*P_INPUT_WIDTH-1:0]   i_n,
    input  logic [P_CHANNELS*2*P_INPUT_WIDTH-1:0]   i_l,
    output logic [P_CHANNELS*2*fft_ow(P_INPUT_WIDTH, P_POINT_POSITION)-1:0] o_p,
    output logic [P_CHANNELS*2*fft_ow(P_INPUT_WIDTH, P_POINT_POSITION)-1:0] o_m,
    output logic                                    o_valid,
    input  logic                                    i_ready
);

    localparam int c_w     = P_INPUT_WIDTH;
    localparam int c_ow    = fft_ow(P_INPUT_WIDTH, P_POINT_POSITION);
    localparam int c_pw    = 2 * c_w + 1;
    localparam int c_xw    = 2 * c_w + 2;
    localparam int c_bw    = P_CHANNELS * 2 * c_w;
    localparam int c_obw   = P_CHANNELS * 2 * c_ow;
    localparam int c_cnt_w = (P_CHANNELS > 1) ? $clog2(P_CHANNELS) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(P_CHANNELS - 1);
    // Half an output LSB, added before the shift in round-half-up mode
    localparam logic signed [c_xw-1:0] c_half =
        c_xw'((P_ROUND == c_round_half_up) ? (2 ** P_POINT_POSITION) / 2 : 0);

    // Sequencing state
    state_e               state_q, state_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic                 valid_q, valid_d;

    // Batch buffer
    logic [c_bw-1:0]      m_q, m_d;
    logic [c_bw-1:0]      n_q, n_d;
    logic [c_bw-1:0]      l_q, l_d;
    logic                 conj_q, conj_d;

    // Product pipeline register with the channel it belongs to
    logic [c_pw-1:0]      prod_re_q, prod_re_d;
    logic [c_pw-1:0]      prod_im_q, prod_im_d;
    logic [c_cnt_w-1:0]   idx_q, idx_d;
    logic                 pvalid_q, pvalid_d;

    // Result registers
    logic [c_obw-1:0]     op_q, op_d;
    logic [c_obw-1:0]     om_q, om_d;

    // Datapath wires
    logic                 w_accept;
    logic [2*c_w-1:0]     w_n_sel;
    logic [2*c_w-1:0]     w_l_sel;
    logic [2*c_w-1:0]     w_m_sel;
    logic [c_pw-1:0]      w_mul_re;
    logic [c_pw-1:0]      w_mul_im;
    logic signed [c_xw-1:0] w_re_x;
    logic signed [c_xw-1:0] w_im_x;
    logic [c_ow-1:0]      w_pr_re;
    logic [c_ow-1:0]      w_pr_im;
    logic [c_ow-1:0]      w_m_re;
    logic [c_ow-1:0]      w_m_im;

    // The single shared multiplier, fed by the channel under the counter
    shared_butterfly_engine_cmul #(
        .P_WIDTH (c_w)
    ) u_cmul (
        .i_a    (w_n_sel),
        .i_b    (w_l_sel),
        .i_conj (conj_q),
        .o_re   (w_mul_re),
        .o_im   (w_mul_im)
    );

    // Handshake and next-state logic for the batch sequencer
    always_comb begin
        o_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && i_ready);
        w_accept = i_valid && o_ready;
        state_d  = state_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    state_d = ST_PROC;
                    cnt_d   = '0;
                end
            end
            ST_PROC: begin
                if (cnt_q == c_last) begin
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_FLUSH: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (i_ready) begin
                    state_d = i_valid ? ST_PROC : ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        valid_d = (state_d == ST_DONE);
    end

    // Batch capture: the buffer only changes on an accepted handshake
    always_comb begin
        m_d    = m_q;
        n_d    = n_q;
        l_d    = l_q;
        conj_d = conj_q;
        if (w_accept) begin
            m_d    = i_m;
            n_d    = i_n;
            l_d    = i_l;
            conj_d = i_conj;
        end
    end

    // Multiplier stage: select the current channel and register its product
    always_comb begin
        w_n_sel   = n_q[cnt_q*2*c_w +: 2*c_w];
        w_l_sel   = l_q[cnt_q*2*c_w +: 2*c_w];
        prod_re_d = w_mul_re;
        prod_im_d = w_mul_im;
        idx_d     = cnt_q;
        pvalid_d  = (state_q == ST_PROC);
    end

    // Rescale, add/sub and load only the channel leaving the product register
    always_comb begin
        w_m_sel = m_q[idx_q*2*c_w +: 2*c_w];
        w_m_re  = {{(c_ow-c_w){w_m_sel[2*c_w-1]}}, w_m_sel[2*c_w-1:c_w]};
        w_m_im  = {{(c_ow-c_w){w_m_sel[c_w-1]}},   w_m_sel[c_w-1:0]};
        w_re_x  = $signed({prod_re_q[c_pw-1], prod_re_q}) + c_half;
        w_im_x  = $signed({prod_im_q[c_pw-1], prod_im_q}) + c_half;
        w_pr_re = c_ow'(w_re_x >>> P_POINT_POSITION);
        w_pr_im = c_ow'(w_im_x >>> P_POINT_POSITION);
        op_d    = op_q;
        om_d    = om_q;
        if (pvalid_q) begin
            op_d[idx_q*2*c_ow +: 2*c_ow] = {w_m_re + w_pr_re, w_m_im + w_pr_im};
            om_d[idx_q*2*c_ow +: 2*c_ow] = {w_m_re - w_pr_re, w_m_im - w_pr_im};
        end
    end

    // State, buffer, pipeline and result registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            m_q       <= '0;
            n_q       <= '0;
            l_q       <= '0;
            conj_q    <= 1'b0;
            prod_re_q <= '0;
            prod_im_q <= '0;
            idx_q     <= '0;
            pvalid_q  <= 1'b0;
            op_q      <= '0;
            om_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            m_q       <= m_d;
            n_q       <= n_d;
            l_q       <= l_d;
            conj_q    <= conj_d;
            prod_re_q <= prod_re_d;
            prod_im_q <= prod_im_d;
            idx_q     <= idx_d;
            pvalid_q  <= pvalid_d;
            op_q      <= op_d;
            om_q      <= om_d;
        end
    end

    assign o_p     = op_q;
    assign o_m     = om_q;
    assign o_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_shared_butterfly_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_shared_butterfly_engine
// Description : Directed self-checking bench for shared_butterfly_engine.
//               Three instances share clock and reset: truncating C=4,
//               rounding C=4 (same stimulus) and truncating C=1.
//               Latency is counted with the handshake cycle as cycle 0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shared_butterfly_engine;

    localparam int W   = 8;
    localparam int P   = 3;
    localparam int C   = 4;
    localparam int OW  = 2 * W - P + 2;
    localparam int BW  = C * 2 * W;
    localparam int OBW = C * 2 * OW;

    logic            CLK     = 1'b0;
    logic            RST_N   = 1'b0;
    logic            i_valid = 1'b0;
    logic            i_conj  = 1'b0;
    logic            i_ready = 1'b0;
    logic [BW-1:0]   i_m     = '0;
    logic [BW-1:0]   i_n     = '0;
    logic [BW-1:0]   i_l     = '0;
    logic            o_ready, o_valid, o_ready_r, o_valid_r;
    logic [OBW-1:0]  o_p, o_m, o_p_r, o_m_r;

    logic            c1_valid = 1'b0;
    logic            c1_conj  = 1'b0;
    logic            c1_ready = 1'b0;
    logic [2*W-1:0]  c1_m = '0;
    logic [2*W-1:0]  c1_n = '0;
    logic [2*W-1:0]  c1_l = '0;
    logic            c1_o_ready, c1_o_valid;
    logic [2*OW-1:0] c1_o_p, c1_o_m;

    int checks = 0;
    int errors = 0;
    int lat;
    logic seen;

    always #5 CLK = ~CLK;

    shared_butterfly_engine #(.P_INPUT_WIDTH(W), .P_POINT_POSITION(P),
                              .P_CHANNELS(C), .P_ROUND(0)) u_dut (
        .CLK(CLK), .RST_N(RST_N), .i_valid(i_valid), .o_ready(o_ready),
        .i_conj(i_conj), .i_m(i_m), .i_n(i_n), .i_l(i_l),
        .o_p(o_p), .o_m(o_m), .o_valid(o_valid), .i_ready(i_ready));

    shared_butterfly_engine #(.P_INPUT_WIDTH(W), .P_POINT_POSITION(P),
                              .P_CHANNELS(C), .P_ROUND(1)) u_dut_r (
        .CLK(CLK), .RST_N(RST_N), .i_valid(i_valid), .o_ready(o_ready_r),
        .i_conj(i_conj), .i_m(i_m), .i_n(i_n), .i_l(i_l),
        .o_p(o_p_r), .o_m(o_m_r), .o_valid(o_valid_r), .i_ready(i_ready));

    shared_butterfly_engine #(.P_INPUT_WIDTH(W), .P_POINT_POSITION(P),
                              .P_CHANNELS(1), .P_ROUND(0)) u_dut_c1 (
        .CLK(CLK), .RST_N(RST_N), .i_valid(c1_valid), .o_ready(c1_o_ready),
        .i_conj(c1_conj), .i_m(c1_m), .i_n(c1_n), .i_l(c1_l),
        .o_p(c1_o_p), .o_m(c1_o_m), .o_valid(c1_o_valid), .i_ready(c1_ready));

    function automatic logic [2*W-1:0] cx(input int re, input int im);
        logic [2*W-1:0] r;
        r = {re[W-1:0], im[W-1:0]};
        return r;
    endfunction

    function automatic int re_of(input logic [OBW-1:0] v, input int k);
        logic signed [OW-1:0] t;
        t = v[k*2*OW+OW +: OW];
        return int'(t);
    endfunction

    function automatic int im_of(input logic [OBW-1:0] v, input int k);
        logic signed [OW-1:0] t;
        t = v[k*2*OW +: OW];
        return int'(t);
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        i_m = '0; i_n = '0; i_l = '0; i_conj = 1'b0;
    endtask

    task automatic scramble();
        i_m    = {$urandom, $urandom};
        i_n    = {$urandom, $urandom};
        i_l    = {$urandom, $urandom};
        i_conj = 1'($urandom % 2);
    endtask

    task automatic set_ch(input int k, input int mr, input int mi, input int nr,
                          input int ni, input int lr, input int li);
        i_m[k*2*W +: 2*W] = cx(mr, mi);
        i_n[k*2*W +: 2*W] = cx(nr, ni);
        i_l[k*2*W +: 2*W] = cx(lr, li);
    endtask

    task automatic wait_valid(output int n);
        n = 1;
        while (o_valid !== 1'b1 && n < 40) begin
            @(negedge CLK);
            n++;
        end
    endtask

    // Offer the prepared batch, garble inputs after acceptance, await results
    task automatic offer(input string tag);
        int n;
        i_valid = 1'b1;
        i_ready = 1'b0;
        #1 chk({tag, "_ready"}, int'(o_ready), 1);
        @(negedge CLK);
        i_valid = 1'b0;
        scramble();
        wait_valid(n);
        chk({tag, "_lat"}, n, 6);
        chk({tag, "_valid_r"}, int'(o_valid_r), 1);
    endtask

    task automatic consume();
        i_ready = 1'b1;
        @(negedge CLK);
        i_ready = 1'b0;
        clear_in();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_ready", int'(o_ready), 1);
        chk("rst_op_zero", int'(o_p == '0), 1);
        chk("rst_om_zero", int'(o_m == '0), 1);

        // Basic butterfly on channel 0
        clear_in();
        set_ch(0, 8, 0, 16, 0, 8, 0);
        offer("basic");
        chk("basic_p_re", re_of(o_p, 0), 24);
        chk("basic_p_im", im_of(o_p, 0), 0);
        chk("basic_m_re", re_of(o_m, 0), -8);
        chk("basic_ch1_zero", re_of(o_p, 1), 0);
        chk("basic_r_p_re", re_of(o_p_r, 0), 24);
        consume();

        // Conjugate mode on channel 2: (8j)*(8j) = -64 ; (8j)*conj(8j) = 64
        set_ch(2, 0, 0, 0, 8, 0, 8);
        i_conj = 1'b0;
        offer("conj0");
        chk("conj0_p_re", re_of(o_p, 2), -8);
        chk("conj0_p_im", im_of(o_p, 2), 0);
        chk("conj0_m_re", re_of(o_m, 2), 8);
        chk("conj0_ch0_overwritten", re_of(o_p, 0), 0);
        consume();
        set_ch(2, 0, 0, 0, 8, 0, 8);
        i_conj = 1'b1;
        offer("conj1");
        chk("conj1_p_re", re_of(o_p, 2), 8);
        chk("conj1_m_re", re_of(o_m, 2), -8);
        consume();

        // Rounding on channel 1: product 4 and -4, rescaled by 8
        set_ch(1, 0, 0, 1, 0, 4, 0);
        offer("rnd_pos");
        chk("rnd_pos_trunc", re_of(o_p, 1), 0);
        chk("rnd_pos_round", re_of(o_p_r, 1), 1);
        consume();
        set_ch(1, 0, 0, -1, 0, 4, 0);
        offer("rnd_neg");
        chk("rnd_neg_trunc", re_of(o_p, 1), -1);
        chk("rnd_neg_round", re_of(o_p_r, 1), 0);
        consume();

        // Mixed complex on channel 3: (3+2j)(7-5j) = 31 - 1j, m = 5-3j
        set_ch(3, 5, -3, 3, 2, 7, -5);
        offer("mix");
        chk("mix_p_re", re_of(o_p, 3), 8);
        chk("mix_p_im", im_of(o_p, 3), -4);
        chk("mix_m_re", re_of(o_m, 3), 2);
        chk("mix_m_im", im_of(o_m, 3), -2);
        chk("mix_r_p_re", re_of(o_p_r, 3), 9);
        chk("mix_r_p_im", im_of(o_p_r, 3), -3);
        chk("mix_r_m_re", re_of(o_m_r, 3), 1);
        chk("mix_r_m_im", im_of(o_m_r, 3), -3);
        consume();

        // Backpressure: hold results 10 cycles while inputs churn
        set_ch(0, 8, 0, 16, 0, 8, 0);
        offer("bp");
        for (int i = 0; i < 10; i++) begin
            scramble();
            i_valid = 1'b1;
            #1;
            chk("bp_ready_low", int'(o_ready), 0);
            chk("bp_valid_held", int'(o_valid), 1);
            chk("bp_p_held", re_of(o_p, 0), 24);
            chk("bp_m_held", re_of(o_m, 0), -8);
            @(negedge CLK);
        end
        // Back-to-back: consume and offer the next batch in the same cycle
        clear_in();
        set_ch(2, 0, 0, 0, 8, 0, 8);
        i_conj  = 1'b1;
        i_valid = 1'b1;
        i_ready = 1'b1;
        #1 chk("b2b_ready", int'(o_ready), 1);
        @(negedge CLK);
        i_valid = 1'b0;
        i_ready = 1'b0;
        scramble();
        wait_valid(lat);
        chk("b2b_lat", lat, 6);
        chk("b2b_p_re", re_of(o_p, 2), 8);
        chk("b2b_m_re", re_of(o_m, 2), -8);
        chk("b2b_ch0_overwritten", re_of(o_p, 0), 0);
        consume();

        // Reset while the counter is at 2
        set_ch(0, 8, 0, 16, 0, 8, 0);
        i_valid = 1'b1;
        @(negedge CLK);
        i_valid = 1'b0;
        repeat (2) @(negedge CLK);
        chk("midrst_cnt", int'(u_dut.cnt_q), 2);
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        chk("midrst_ready", int'(o_ready), 1);
        chk("midrst_valid", int'(o_valid), 0);
        chk("midrst_op_zero", int'(o_p == '0), 1);
        chk("midrst_om_zero", int'(o_m == '0), 1);
        seen = 1'b0;
        repeat (8) begin
            @(negedge CLK);
            seen = seen | o_valid;
        end
        chk("midrst_no_valid", int'(seen), 0);
        clear_in();
        set_ch(3, 5, -3, 3, 2, 7, -5);
        offer("fresh");
        chk("fresh_p_re", re_of(o_p, 3), 8);
        chk("fresh_m_im", im_of(o_m, 3), -2);
        consume();

        // Extremes on every channel: n = l = (-128,-128), m = (-128,127)
        for (int k = 0; k < C; k++) set_ch(k, -128, 127, -128, -128, -128, -128);
        offer("ext0");
        for (int k = 0; k < C; k++) begin
            chk("ext0_p_re", re_of(o_p, k), -128);
            chk("ext0_p_im", im_of(o_p, k), 4223);
            chk("ext0_m_re", re_of(o_m, k), -128);
            chk("ext0_m_im", im_of(o_m, k), -3969);
        end
        chk("ext0_r_p_im", im_of(o_p_r, 0), 4223);
        consume();
        for (int k = 0; k < C; k++) set_ch(k, -128, 127, -128, -128, -128, -128);
        i_conj = 1'b1;
        offer("ext1");
        for (int k = 0; k < C; k++) begin
            chk("ext1_p_re", re_of(o_p, k), 3968);
            chk("ext1_p_im", im_of(o_p, k), 127);
            chk("ext1_m_re", re_of(o_m, k), -4224);
            chk("ext1_m_im", im_of(o_m, k), 127);
        end
        chk("ext1_r_m_re", re_of(o_m_r, 1), -4224);
        consume();

        // Single-channel instance: latency 3
        c1_m     = cx(8, 0);
        c1_n     = cx(16, 0);
        c1_l     = cx(8, 0);
        c1_valid = 1'b1;
        #1 chk("c1_ready", int'(c1_o_ready), 1);
        @(negedge CLK);
        c1_valid = 1'b0;
        c1_n     = cx(99, 99);
        lat      = 1;
        while (c1_o_valid !== 1'b1 && lat < 40) begin
            @(negedge CLK);
            lat++;
        end
        chk("c1_lat", lat, 3);
        chk("c1_p_re", re_of(OBW'(c1_o_p), 0), 24);
        chk("c1_m_re", re_of(OBW'(c1_o_m), 0), -8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shared_butterfly_engine.md
SHARED_BUTTERFLY_ENGINE -- requirements
Module: shared_butterfly_engine

Interface
REQ-001 SHALL have parameter P_INPUT_WIDTH, default 8: width W of each real/imag component.
REQ-002 SHALL have parameter P_POINT_POSITION, default 3: fractional bits P of each component.
REQ-003 SHALL have parameter P_CHANNELS, default 4: number of butterflies C per batch, legal range 1..16.
REQ-004 SHALL have parameter P_ROUND, default 0: 0 selects truncate, 1 selects round-half-up on the product rescale.
REQ-005 SHALL have port CLK, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 SHALL have port RST_N, input, 1 bit: synchronous active-low reset.
REQ-007 SHALL have port i_valid, input, 1 bit: batch offered.
REQ-008 SHALL have port o_ready, output, 1 bit: batch can be accepted this cycle.
REQ-009 SHALL have port i_conj, input, 1 bit: multiply by conj(l); captured with the batch.
REQ-010 SHALL have ports i_m, i_n and i_l, input, C*2W bits each: packed complex operands; channel k occupies bits [k*2W +: 2W], real in the upper W bits, imag in the lower W bits, two's complement.
REQ-011 SHALL have ports o_p and o_m, output, C*2*OW bits each, with OW = 2W-P+2: channel k occupies [k*2OW +: 2OW], real in the upper OW bits.
REQ-012 SHALL have port o_valid, output, 1 bit: results held and valid.
REQ-013 SHALL have port i_ready, input, 1 bit: downstream consumes results.

Function
REQ-014 SHALL compute, per channel k, prod = n_k * l_k, or n_k * conj(l_k) when the captured i_conj = 1.
- prod real and imag each held at 2W+1 bits, full precision.
REQ-015 SHALL rescale each prod component by an arithmetic right shift of P.
- P_ROUND = 1: add 2^(P-1) before the shift.
- Result width 2W+1-P.
REQ-016 SHALL sign-extend m_k components to OW bits and output o_p_k = m_k + prod and o_m_k = m_k - prod, with no overflow possible at width OW.
REQ-017 SHALL use exactly one shared complex multiplier and one add/sub pair, time-multiplexed across channels.
REQ-018 SHALL implement FSM states IDLE, CAPTURE-free PROC, FLUSH and DONE, with transitions:
- IDLE -> PROC on i_valid && o_ready.
- PROC -> FLUSH when the channel counter reaches C-1.
- FLUSH -> DONE after one cycle.
- DONE -> IDLE on i_ready, or DONE -> PROC if i_valid is also high.
REQ-019 SHALL register all of i_m, i_n, i_l and i_conj into an internal batch buffer on acceptance; later input changes SHALL NOT affect the batch.
REQ-020 SHALL use a channel counter that starts at 0 on entering PROC and advances by 1 per cycle.
- The multiplier output is registered once (1-cycle pipeline).
- Channel k's output register loads one cycle after counter = k.
REQ-021 SHALL assert o_valid exactly C+2 cycles after the accepting edge.
REQ-022 SHALL drive o_ready = 1 in IDLE, and in DONE when i_ready = 1 (back-to-back batches); 0 otherwise.
REQ-023 SHALL hold o_p, o_m and o_valid stable in DONE while i_ready = 0, indefinitely.
REQ-024 SHALL leave the output registers unchanged outside their load cycle, so the previous batch stays visible until overwritten.
REQ-025 SHALL ignore i_valid while o_ready = 0; no batch is lost or duplicated.
REQ-026 SHALL, for C = 1, pass through PROC for one cycle, giving a latency of 3.

Reset
REQ-027 SHALL, when RST_N = 0 at a rising edge, set the FSM to IDLE, the counter to 0, o_valid to 0, o_p and o_m to all-zero, and the batch buffer to 0.
REQ-028 SHALL, on reset mid-batch (PROC, FLUSH or DONE), discard the batch with no o_valid pulse, and show o_ready = 1 on the first cycle after reset deasserts.

Structure
REQ-029 SHALL place the state encoding, the OW width function and the rounding-mode constants in the shared package fft_pkg.
REQ-030 SHALL instantiate the existing combinational complex multiplier as its single sub-module, operating on the full-precision product; the rescale/round logic is local.

Verification (W=8, P=3, C=4, all other channels zero)
REQ-031 SHALL cover basic butterfly:
- Stimulus: ch0 m=(8,0), n=(16,0), l=(8,0), i_conj=0.
- Response: o_p ch0=(24,0), o_m ch0=(-8,0); o_valid exactly 6 cycles after accept.
REQ-032 SHALL cover conjugate mode:
- Stimulus: ch2 m=(0,0), n=(0,8), l=(0,8).
- Response: i_conj=0 gives o_p ch2=(-8,0); i_conj=1 gives o_p ch2=(8,0) and o_m ch2=(-8,0).
REQ-033 SHALL cover rounding:
- Stimulus: ch1 n=(1,0), l=(4,0), m=0.
- Response: P_ROUND=0 gives o_p ch1=(0,0); P_ROUND=1 gives (1,0); n=(-1,0) with P_ROUND=0 gives (-1,0).
REQ-034 SHALL cover backpressure and back-to-back:
- Stimulus: hold i_ready=0 for 10 cycles in DONE while inputs toggle.
- Response: outputs constant and o_ready=0.
- Then: i_ready=1 with i_valid=1 gives o_ready=1 in that cycle, and the second batch o_valid arrives 6 cycles later.
REQ-035 SHALL cover reset mid-batch:
- Stimulus: RST_N=0 for one cycle when counter=2.
- Response: o_valid stays 0, outputs zero, o_ready=1 the next cycle, and a fresh batch completes correctly.
REQ-036 SHALL cover extremes:
- Stimulus: all channels n=l=(-128,-128), m=(-128,127), both i_conj values.
- Response: outputs equal a reference model bit-exactly, with no wrap.
